// File: rtl/ifft_core8_seq.sv
// Sequential 8-point radix-2 DIT inverse FFT: load in natural order, 12 in-place conjugate-twiddle butterflies, stream out.
// Build option IFFT_SCALE_EN: when defined each stage shifts by F+1 (true 1/N IFFT); otherwise by F (N*IFFT).
module ifft_core8_seq #(
  parameter int FFT_DATA_WD = 10,
  parameter int FFT_WN_WD   = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fft_din_vld,
  output logic                          fft_din_rdy,
  input  logic signed [FFT_DATA_WD-1:0] fft_din_re,
  input  logic signed [FFT_DATA_WD-1:0] fft_din_im,
  output logic                          fft_dout_vld,
  input  logic                          fft_dout_rdy,
  output logic signed [FFT_DATA_WD-1:0] fft_dout_re,
  output logic signed [FFT_DATA_WD-1:0] fft_dout_im,
  output logic [2:0]                    fft_dout_idx,
  output logic                          fft_busy
);
  localparam int D  = FFT_DATA_WD;
  localparam int F  = FFT_WN_WD - 2;
  localparam int IW = FFT_DATA_WD + FFT_WN_WD + 2;
`ifdef IFFT_SCALE_EN
  localparam int SH = F + 1;
`else
  localparam int SH = F;
`endif
  localparam logic signed [FFT_WN_WD-1:0] W_ONE = FFT_WN_WD'(1 << F);
  localparam logic signed [FFT_WN_WD-1:0] W_R2  = FFT_WN_WD'((181 * (1 << F) + 128) / 256);

  typedef struct packed {
    logic signed [D-1:0] re;
    logic signed [D-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {LOAD, CALC, OUT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q;
  logic [1:0]  stg_q, bf_q;
  cplx_t [7:0] mem_q;

  logic din_acc, dout_acc, calc_last;
  logic [2:0] top, bot;
  logic [1:0] tw_e;
  logic signed [FFT_WN_WD-1:0] w_re, w_im;
  cplx_t a, b, y_top, y_bot;
  logic signed [IW-1:0] a_re, a_im, b_re, b_im, wx_re, wx_im, p_re, p_im;

  function automatic logic [2:0] bitrev3(input logic [2:0] k);
    return {k[0], k[1], k[2]};
  endfunction

  assign din_acc   = fft_din_vld && fft_din_rdy;
  assign dout_acc  = fft_dout_vld && fft_dout_rdy;
  assign calc_last = (stg_q == 2'd2) && (bf_q == 2'd3);

  assign fft_din_rdy  = (state_q == LOAD);
  assign fft_busy     = (state_q != LOAD);
  assign fft_dout_vld = (state_q == OUT);
  assign fft_dout_idx = (state_q == OUT) ? cnt_q : 3'd0;
  assign fft_dout_re  = (state_q == OUT) ? mem_q[cnt_q].re : '0;
  assign fft_dout_im  = (state_q == OUT) ? mem_q[cnt_q].im : '0;

  // Butterfly addressing: stage s pairs entries 2^s apart; twiddle step shrinks as the span grows.
  always_comb begin
    top  = 3'd0;
    bot  = 3'd0;
    tw_e = 2'd0;
    case (stg_q)
      2'd0: begin top = {bf_q, 1'b0};           bot = top | 3'd1; tw_e = 2'd0;           end
      2'd1: begin top = {bf_q[1], 1'b0, bf_q[0]}; bot = top | 3'd2; tw_e = {bf_q[0], 1'b0}; end
      default: begin top = {1'b0, bf_q};        bot = top | 3'd4; tw_e = bf_q;           end
    endcase
  end

  // conj(W8^e): positive-angle rotation for the inverse transform
  always_comb begin
    w_re = W_ONE;
    w_im = '0;
    case (tw_e)
      2'd0: begin w_re = W_ONE; w_im = '0;    end
      2'd1: begin w_re = W_R2;  w_im = W_R2;  end
      2'd2: begin w_re = '0;    w_im = W_ONE; end
      default: begin w_re = -W_R2; w_im = W_R2; end
    endcase
  end

  always_comb begin
    a     = mem_q[top];
    b     = mem_q[bot];
    a_re  = {{(IW-D){a.re[D-1]}}, a.re};
    a_im  = {{(IW-D){a.im[D-1]}}, a.im};
    b_re  = {{(IW-D){b.re[D-1]}}, b.re};
    b_im  = {{(IW-D){b.im[D-1]}}, b.im};
    wx_re = {{(IW-FFT_WN_WD){w_re[FFT_WN_WD-1]}}, w_re};
    wx_im = {{(IW-FFT_WN_WD){w_im[FFT_WN_WD-1]}}, w_im};
    p_re  = wx_re * b_re - wx_im * b_im;
    p_im  = wx_re * b_im + wx_im * b_re;
    // floor via arithmetic shift, then wrap to the sample width
    y_top.re = D'(((a_re <<< F) + p_re) >>> SH);
    y_top.im = D'(((a_im <<< F) + p_im) >>> SH);
    y_bot.re = D'(((a_re <<< F) - p_re) >>> SH);
    y_bot.im = D'(((a_im <<< F) - p_im) >>> SH);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (din_acc && cnt_q == 3'd7) state_d = CALC;
      CALC:    if (calc_last) state_d = OUT;
      OUT:     if (dout_acc && cnt_q == 3'd7) state_d = LOAD;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // cnt_q is the load beat in LOAD and the output index in OUT; it wraps to 0 at each frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 3'd0;
      stg_q <= 2'd0;
      bf_q  <= 2'd0;
      mem_q <= '0;
    end else begin
      case (state_q)
        LOAD: if (din_acc) begin
          mem_q[bitrev3(cnt_q)] <= {fft_din_re, fft_din_im};
          cnt_q                 <= cnt_q + 3'd1;
        end
        CALC: begin
          mem_q[top] <= y_top;
          mem_q[bot] <= y_bot;
          bf_q       <= bf_q + 2'd1;
          if (bf_q == 2'd3) stg_q <= calc_last ? 2'd0 : stg_q + 2'd1;
        end
        OUT: if (dout_acc) cnt_q <= cnt_q + 3'd1;
        default: ;
      endcase
    end
  end

endmodule
